// File: rtl/ipm_distributed_sdpram_v2_0_ram_bank.sv
// Single-clock simple-dual-port distributed RAM with byte enables, 0/1/2-cycle read latency and a zeroing sweep.
// Define IPM_DSRAM_BYPASS_EN to forward same-cycle, same-address write data into the read result.
module ipm_distributed_sdpram_v2_0_ram_bank #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_SIZE  = 8,
    parameter int RD_LATENCY = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [DATA_WIDTH/BYTE_SIZE-1:0]  wr_be,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    input  logic                             clr_req,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic                             init_busy
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_LANES = DATA_WIDTH / BYTE_SIZE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [ADDR_WIDTH-1:0]   clr_addr_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    wr_commit;
    logic                    rd_accept;
    logic [DATA_WIDTH-1:0]   wr_merged;
    logic [DATA_WIDTH-1:0]   rd_word;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_LANES-1:0]  lanes
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (lanes[k]) begin
                res[k*BYTE_SIZE +: BYTE_SIZE] = new_word[k*BYTE_SIZE +: BYTE_SIZE];
            end else begin
                res[k*BYTE_SIZE +: BYTE_SIZE] = old_word[k*BYTE_SIZE +: BYTE_SIZE];
            end
        end
        return res;
    endfunction

    // Clear-engine next state: sweep ends on the edge that writes the last word.
    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end else begin
                    state_next    = IDLE;
                end
            end
            CLEAR: begin
                clr_addr_next = clr_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                if (clr_addr == LAST_ADDR) begin
                    state_next = IDLE;
                end else begin
                    state_next = CLEAR;
                end
            end
            default: begin
                state_next    = IDLE;
                clr_addr_next = '0;
            end
        endcase
    end

    // FSM state, sweep counter and busy flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
            clr_addr  <= '0;
            init_busy <= (CLR_ON_RST != 0);
        end else begin
            state     <= state_next;
            clr_addr  <= clr_addr_next;
            init_busy <= (state_next == CLEAR);
        end
    end

    assign wr_commit = wr_en & (state == IDLE) & ~rst;
    assign rd_accept = rd_en & ~init_busy;
    assign wr_merged = merge_lanes(mem[wr_addr], wr_data, wr_be);

`ifdef IPM_DSRAM_BYPASS_EN
    assign rd_word = (wr_commit && (wr_addr == rd_addr)) ? wr_merged : mem[rd_addr];
`else
    assign rd_word = mem[rd_addr];
`endif

    // Array write port; the sweep owns the port while clearing and reset blocks all writes.
    always_ff @(posedge clk) begin
        if (!rst && (state == CLEAR)) begin
            mem[clr_addr] <= '0;
        end else if (wr_commit) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    generate
        if (RD_LATENCY == 0) begin : g_lat0
            assign rd_data  = rd_word;
            assign rd_valid = rd_accept;
        end else begin : g_lat12
            logic [DATA_WIDTH-1:0] data_s1;
            logic                  valid_s1;

            // First read stage: captures on accept, holds otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_s1  <= '0;
                    valid_s1 <= 1'b0;
                end else begin
                    valid_s1 <= rd_accept;
                    if (rd_accept) begin
                        data_s1 <= rd_word;
                    end
                end
            end

            if (RD_LATENCY == 1) begin : g_lat1
                assign rd_data  = data_s1;
                assign rd_valid = valid_s1;
            end else begin : g_lat2
                logic [DATA_WIDTH-1:0] data_s2;
                logic                  valid_s2;

                // Output stage moves data and valid together.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        data_s2  <= '0;
                        valid_s2 <= 1'b0;
                    end else begin
                        valid_s2 <= valid_s1;
                        if (valid_s1) begin
                            data_s2 <= data_s1;
                        end
                    end
                end

                assign rd_data  = data_s2;
                assign rd_valid = valid_s2;
            end
        end
    endgenerate

endmodule
